// File: rtl/ps2_scan_decoder.sv
// rtl/ps2_scan_decoder.sv - PS/2 keyboard frame receiver and scan-code prefix decoder
// Optional parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_scan_decoder #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    logic          clk_s1_q, clk_s2_q, clk_prev_q;
    logic          dat_s1_q, dat_s2_q;
    logic          fall;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic [7:0]    key_code_q, key_code_d;
    logic          key_ext_q, key_ext_d;
    logic          key_break_q, key_break_d;
    logic          key_valid_q, key_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          frame_good;
`ifdef PS2_PARITY_CHECK_EN
    logic          parity_q, parity_d;
`endif

    // Synchronizers idle high so that reset never fakes a falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall = clk_prev_q & ~clk_s2_q;

`ifdef PS2_PARITY_CHECK_EN
    assign frame_good = dat_s2_q & (^{shift_q, parity_q});
`else
    assign frame_good = dat_s2_q;
`endif

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        key_code_d  = key_code_q;
        key_ext_d   = key_ext_q;
        key_break_d = key_break_q;
        key_valid_d = 1'b0;
        frame_err_d = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_d    = parity_q;
`endif

        if (state_q == ST_IDLE || fall) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        if (state_q != ST_IDLE && !fall && tmo_q == TMO_LAST) begin
            state_d     = ST_IDLE;
            tmo_d       = '0;
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
        end else if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        frame_err_d = 1'b1;
                        ext_d       = 1'b0;
                        brk_d       = 1'b0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_d = dat_s2_q;
`endif
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (!frame_good) begin
                        frame_err_d = 1'b1;
                        ext_d       = 1'b0;
                        brk_d       = 1'b0;
                    end else if (shift_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (shift_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else begin
                        key_valid_d = 1'b1;
                        key_code_d  = shift_q;
                        key_ext_d   = ext_q;
                        key_break_d = brk_q;
                        ext_d       = 1'b0;
                        brk_d       = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            tmo_q       <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            key_code_q  <= 8'h00;
            key_ext_q   <= 1'b0;
            key_break_q <= 1'b0;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tmo_q       <= tmo_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            key_code_q  <= key_code_d;
            key_ext_q   <= key_ext_d;
            key_break_q <= key_break_d;
            key_valid_q <= key_valid_d;
            frame_err_q <= frame_err_d;
`ifdef PS2_PARITY_CHECK_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign key_code  = key_code_q;
    assign key_ext   = key_ext_q;
    assign key_break = key_break_q;
    assign key_valid = key_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb/tb_ps2_scan_decoder.sv - self-checking bench for ps2_scan_decoder
module tb_ps2_scan_decoder;

    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_code;
    logic       key_ext, key_break, key_valid, frame_err;

    ps2_scan_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_code  (key_code),
        .key_ext   (key_ext),
        .key_break (key_break),
        .key_valid (key_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    int         valid_cnt = 0, err_cnt = 0, both_cnt = 0, stab_bad = 0;
    logic [7:0] s_code = 8'h00, last_code = 8'h00;
    logic       s_ext = 1'b0, s_brk = 1'b0, last_ext = 1'b0, last_brk = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_code = 8'h00;
            last_ext  = 1'b0;
            last_brk  = 1'b0;
        end else begin
            if (key_valid && frame_err) both_cnt++;
            if (key_valid) begin
                valid_cnt++;
                s_code = key_code;  s_ext = key_ext;  s_brk = key_break;
                last_code = key_code; last_ext = key_ext; last_brk = key_break;
            end else if (key_code !== last_code || key_ext !== last_ext || key_break !== last_brk) begin
                stab_bad++;
            end
            if (frame_err) err_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Reference model: prefix flags accumulate until a key byte or any error.
    logic m_ext = 1'b0, m_brk = 1'b0;

    task automatic model(input logic [7:0] b, input logic pf, input logic st,
                         output logic ev, output logic ee, output logic [7:0] ec,
                         output logic ex, output logic eb);
        logic par, good;
        par  = ((~^b) ^ pf);
`ifdef PS2_PARITY_CHECK_EN
        good = st && ($countones({b, par}) % 2 == 1);
`else
        good = st;
`endif
        ev = 0; ee = 0; ec = 8'h00; ex = 0; eb = 0;
        if (!good) begin
            ee = 1; m_ext = 0; m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            ev = 1; ec = b; ex = m_ext; eb = m_brk;
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic send_bit(input logic v);
        ps2_data = v;
        repeat (4) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (4) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_frame(input string name, input logic [7:0] b, input logic pf, input logic st,
                            input logic ev, input logic ee, input logic [7:0] ec,
                            input logic ex, input logic eb);
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ pf);
        send_bit(st);
        settle();
        check({name, ".valid"}, valid_cnt - v0, {31'd0, ev});
        check({name, ".err"}, err_cnt - e0, {31'd0, ee});
        if (ev) begin
            check({name, ".code"}, {24'd0, s_code}, {24'd0, ec});
            check({name, ".ext"}, {31'd0, s_ext}, {31'd0, ex});
            check({name, ".brk"}, {31'd0, s_brk}, {31'd0, eb});
        end
    endtask

    task automatic model_frame(input string name, input logic [7:0] b, input logic pf, input logic st);
        logic ev, ee, ex, eb;
        logic [7:0] ec;
        model(b, pf, st, ev, ee, ec, ex, eb);
        do_frame(name, b, pf, st, ev, ee, ec, ex, eb);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       pf;
        logic       st;
        logic       ev;
        logic       ee;
        logic [7:0] ec;
        logic       ex;
        logic       eb;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int v0, e0;
        logic ev, ee, ex, eb;
        logic [7:0] ec;

        tbl[0]  = '{8'h1C, 0, 1, 1, 0, 8'h1C, 0, 0};
        tbl[1]  = '{8'hF0, 0, 1, 0, 0, 8'h00, 0, 0};
        tbl[2]  = '{8'h1C, 0, 1, 1, 0, 8'h1C, 0, 1};
        tbl[3]  = '{8'hE0, 0, 1, 0, 0, 8'h00, 0, 0};
        tbl[4]  = '{8'hF0, 0, 1, 0, 0, 8'h00, 0, 0};
        tbl[5]  = '{8'h75, 0, 1, 1, 0, 8'h75, 1, 1};
        tbl[6]  = '{8'h1C, 0, 1, 1, 0, 8'h1C, 0, 0};
        tbl[7]  = '{8'hF0, 0, 1, 0, 0, 8'h00, 0, 0};
        tbl[8]  = '{8'hE0, 0, 1, 0, 0, 8'h00, 0, 0};
        tbl[9]  = '{8'hE0, 0, 1, 0, 0, 8'h00, 0, 0};
        tbl[10] = '{8'h6B, 0, 1, 1, 0, 8'h6B, 1, 1};
        tbl[11] = '{8'hE1, 0, 1, 1, 0, 8'hE1, 0, 0};
`ifdef PS2_PARITY_CHECK_EN
        tbl[12] = '{8'h1C, 1, 1, 0, 1, 8'h00, 0, 0};
`else
        tbl[12] = '{8'h1C, 1, 1, 1, 0, 8'h1C, 0, 0};
`endif
        tbl[13] = '{8'hE0, 0, 1, 0, 0, 8'h00, 0, 0};
        tbl[14] = '{8'h1C, 0, 0, 0, 1, 8'h00, 0, 0};
        tbl[15] = '{8'h1C, 0, 1, 1, 0, 8'h1C, 0, 0};
        tbl[16] = '{8'h00, 0, 1, 1, 0, 8'h00, 0, 0};
        tbl[17] = '{8'hFF, 0, 1, 1, 0, 8'hFF, 0, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst.code", {24'd0, key_code}, 32'h0);
        check("rst.ext", {31'd0, key_ext}, 32'h0);
        check("rst.brk", {31'd0, key_break}, 32'h0);
        check("rst.valid", {31'd0, key_valid}, 32'h0);
        check("rst.err", {31'd0, frame_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        for (int i = 0; i < 18; i++) begin
            model(tbl[i].data, tbl[i].pf, tbl[i].st, ev, ee, ec, ex, eb);
            do_frame($sformatf("tbl%0d", i), tbl[i].data, tbl[i].pf, tbl[i].st,
                     tbl[i].ev, tbl[i].ee, tbl[i].ec, tbl[i].ex, tbl[i].eb);
        end

        // Start-bit error clears a pending prefix.
        model_frame("se.pre", 8'hF0, 0, 1);
        v0 = valid_cnt; e0 = err_cnt;
        send_bit(1'b1);
        settle();
        check("se.err", err_cnt - e0, 32'd1);
        check("se.valid", valid_cnt - v0, 32'd0);
        m_ext = 0; m_brk = 0;
        do_frame("se.next", 8'h1C, 0, 1, 1, 0, 8'h1C, 0, 0);

        // Timeout after 4 data bits.
        model_frame("to.pre", 8'hF0, 0, 1);
        v0 = valid_cnt; e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        repeat (TMO + 30) @(posedge clk);
        @(negedge clk);
        check("to.err", err_cnt - e0, 32'd1);
        check("to.valid", valid_cnt - v0, 32'd0);
        m_ext = 0; m_brk = 0;
        do_frame("to.next", 8'h1C, 0, 1, 1, 0, 8'h1C, 0, 0);

        // Reset in the middle of an E0 frame, with an earlier E0 pending.
        model_frame("rm.pre", 8'hE0, 0, 1);
        v0 = valid_cnt; e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rm.code", {24'd0, key_code}, 32'h0);
        repeat (TMO + 30) @(posedge clk);
        @(negedge clk);
        check("rm.valid", valid_cnt - v0, 32'd0);
        check("rm.err", err_cnt - e0, 32'd0);
        m_ext = 0; m_brk = 0;
        do_frame("rm.next", 8'h75, 0, 1, 1, 0, 8'h75, 0, 0);

        // Randomized back-to-back frames against the model.
        for (int i = 0; i < 60; i++) begin
            logic [7:0] b;
            logic pf, st;
            int r;
            r = $urandom_range(0, 9);
            b = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom);
            pf = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 11) != 0);
            model_frame($sformatf("rnd%0d", i), b, pf, st);
        end

        check("no_both", both_cnt, 32'd0);
        check("stable", stab_bad, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
